// File: rtl/res_st_sched.sv
// res_st_sched: reservation-station slot allocator and issue scheduler.
// Hands out the lowest free entry to the front end, tracks valid/ready per
// entry, accepts operand wakeups and selects ready entries round-robin for
// issue. An entry is freed by its issue.
//
// Build option: define QU_RES_ST_DUAL_ISSUE_EN to enable the second issue
// port. When it is undefined only port 0 selects and port 1 is tied to zero.
module res_st_sched #(
   parameter int RES_ST_DEPTH = 16,
   parameter int ADDR_W       = $clog2(RES_ST_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alloc_req,
   input  logic              alloc_rdy_in,
   output logic              alloc_gnt,
   output logic [ADDR_W-1:0] alloc_addr,
   input  logic              wake_en,
   input  logic [ADDR_W-1:0] wake_addr,
   input  logic              schedule_en,
   output logic              iss0_valid,
   output logic [ADDR_W-1:0] iss0_addr,
   output logic              iss1_valid,
   output logic [ADDR_W-1:0] iss1_addr,
   output logic [ADDR_W:0]   free_cnt,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(RES_ST_DEPTH);

   // Per-entry state and round-robin pointer
   logic [RES_ST_DEPTH-1:0] valid_q, valid_d;
   logic [RES_ST_DEPTH-1:0] ready_q, ready_d;
   logic [ADDR_W-1:0]       rr_ptr_q, rr_ptr_d;

   // Registered outputs
   logic              iss0_valid_q, iss0_valid_d;
   logic [ADDR_W-1:0] iss0_addr_q, iss0_addr_d;
   logic              iss1_valid_q, iss1_valid_d;
   logic [ADDR_W-1:0] iss1_addr_q, iss1_addr_d;
   logic [ADDR_W:0]   free_cnt_q, free_cnt_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;

   // Allocation and selection intermediates
   logic                    alloc_gnt_s;
   logic [ADDR_W-1:0]       alloc_idx_s;
   logic                    wake_hit_s;
   logic                    alloc_wake_s;
   logic [RES_ST_DEPTH-1:0] cand_s;
   logic                    sel_en_s;
   logic                    p0_found_s;
   logic [ADDR_W-1:0]       p0_idx_s;
   logic                    p0_take_s;
   logic                    p1_take_s;
   logic [ADDR_W-1:0]       p1_idx_s;
   logic [1:0]              issued_s;
`ifdef QU_RES_ST_DUAL_ISSUE_EN
   logic [RES_ST_DEPTH-1:0] p0_mask_s;
   logic [RES_ST_DEPTH-1:0] cand1_s;
   logic                    p1_found_s;
`endif

   // First set bit of vec scanning upward from start with wrap-around.
   // Returns {found, index}; index is 0 when nothing is set.
   function automatic logic [ADDR_W:0] find_first(
      input logic [RES_ST_DEPTH-1:0] vec,
      input logic [ADDR_W-1:0]       start
   );
      logic              found;
      logic [ADDR_W-1:0] idx;
      logic [ADDR_W-1:0] pos;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < RES_ST_DEPTH; i++) begin
         pos = start + ADDR_W'(i);
         if (vec[pos] && !found) begin
            found = 1'b1;
            idx   = pos;
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   // Lowest free entry; scanning downward leaves the smallest free index.
   always_comb begin
      alloc_idx_s = '0;
      for (int i = RES_ST_DEPTH - 1; i >= 0; i--) begin
         alloc_idx_s = (!valid_q[i]) ? ADDR_W'(i) : alloc_idx_s;
      end
      alloc_gnt_s  = alloc_req & ~full_q & ~flush;
      alloc_wake_s = wake_en & (wake_addr == alloc_idx_s);
      // A wakeup only counts for a live entry or the one being allocated now
      wake_hit_s   = wake_en & ~flush &
                     (valid_q[wake_addr] | (alloc_gnt_s & (wake_addr == alloc_idx_s)));
   end

   assign alloc_gnt  = alloc_gnt_s;
   assign alloc_addr = alloc_idx_s;

   // Round-robin pick of up to two ready entries from registered state only
   always_comb begin
      cand_s                   = valid_q & ready_q;
      sel_en_s                 = schedule_en & ~flush;
      {p0_found_s, p0_idx_s}   = find_first(cand_s, rr_ptr_q);
      p0_take_s                = sel_en_s & p0_found_s;
`ifdef QU_RES_ST_DUAL_ISSUE_EN
      p0_mask_s                = '0;
      p0_mask_s[p0_idx_s]      = 1'b1;
      cand1_s                  = cand_s & ~p0_mask_s;
      {p1_found_s, p1_idx_s}   = find_first(cand1_s, p0_idx_s + ADDR_W'(1));
      p1_take_s                = p0_take_s & p1_found_s;
`else
      p1_idx_s                 = '0;
      p1_take_s                = 1'b0;
`endif
      issued_s                 = {1'b0, p0_take_s} + {1'b0, p1_take_s};
   end

   // Next-state for entry valid/ready bits and the round-robin pointer
   always_comb begin
      valid_d  = valid_q;
      ready_d  = ready_q;
      rr_ptr_d = rr_ptr_q;
      if (flush) begin
         valid_d  = '0;
         ready_d  = '0;
         rr_ptr_d = '0;
      end else begin
         if (wake_hit_s) begin
            ready_d[wake_addr] = 1'b1;
         end else begin
            ready_d = ready_d;
         end
         // Issued entries are freed at this edge
         if (p0_take_s) begin
            valid_d[p0_idx_s] = 1'b0;
            ready_d[p0_idx_s] = 1'b0;
         end else begin
            valid_d = valid_d;
         end
         if (p1_take_s) begin
            valid_d[p1_idx_s] = 1'b0;
            ready_d[p1_idx_s] = 1'b0;
         end else begin
            valid_d = valid_d;
         end
         // Allocated entry is never one being issued: issued entries are valid
         if (alloc_gnt_s) begin
            valid_d[alloc_idx_s] = 1'b1;
            ready_d[alloc_idx_s] = alloc_rdy_in | alloc_wake_s;
         end else begin
            valid_d = valid_d;
         end
         // Pointer moves past the last entry actually selected
         if (p1_take_s) begin
            rr_ptr_d = p1_idx_s + ADDR_W'(1);
         end else if (p0_take_s) begin
            rr_ptr_d = p0_idx_s + ADDR_W'(1);
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end
   end

   // Next-state for issue ports, free count and occupancy flags
   always_comb begin
      iss0_valid_d = p0_take_s;
      iss1_valid_d = p1_take_s;
      iss0_addr_d  = p0_take_s ? p0_idx_s : iss0_addr_q;
      iss1_addr_d  = p1_take_s ? p1_idx_s : iss1_addr_q;
      if (flush) begin
         free_cnt_d = DEPTH_CNT;
      end else begin
         free_cnt_d = free_cnt_q + (ADDR_W+1)'(issued_s) - (ADDR_W+1)'(alloc_gnt_s);
      end
      full_d  = (free_cnt_d == '0);
      empty_d = (free_cnt_d == DEPTH_CNT);
   end

   // Entry state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= '0;
         ready_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         ready_q  <= ready_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iss0_valid_q <= 1'b0;
         iss0_addr_q  <= '0;
         iss1_valid_q <= 1'b0;
         iss1_addr_q  <= '0;
         free_cnt_q   <= DEPTH_CNT;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
      end else begin
         iss0_valid_q <= iss0_valid_d;
         iss0_addr_q  <= iss0_addr_d;
         iss1_valid_q <= iss1_valid_d;
         iss1_addr_q  <= iss1_addr_d;
         free_cnt_q   <= free_cnt_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
      end
   end

   assign iss0_valid = iss0_valid_q;
   assign iss0_addr  = iss0_addr_q;
   assign iss1_valid = iss1_valid_q;
   assign iss1_addr  = iss1_addr_q;
   assign free_cnt   = free_cnt_q;
   assign full       = full_q;
   assign empty      = empty_q;

endmodule

// File: tb/tb_res_st_sched.sv
// Self-checking bench for res_st_sched: directed scenarios plus randomized
// traffic, compared each cycle against an array/queue-based reference model.
module tb_res_st_sched;
   localparam int D  = 16;
   localparam int AW = 4;
`ifdef QU_RES_ST_DUAL_ISSUE_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          flush, alloc_req, alloc_rdy_in, wake_en, schedule_en;
   logic [AW-1:0] wake_addr, alloc_addr, iss0_addr, iss1_addr;
   logic          alloc_gnt, iss0_valid, iss1_valid, full, empty;
   logic [AW:0]   free_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_valid[D];
   bit m_ready[D];
   int m_rr;

   always #5 clk = ~clk;

   res_st_sched #(.RES_ST_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_req(alloc_req), .alloc_rdy_in(alloc_rdy_in),
      .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
      .wake_en(wake_en), .wake_addr(wake_addr), .schedule_en(schedule_en),
      .iss0_valid(iss0_valid), .iss0_addr(iss0_addr),
      .iss1_valid(iss1_valid), .iss1_addr(iss1_addr),
      .free_cnt(free_cnt), .full(full), .empty(empty)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int m_free();
      int n = D;
      for (int i = 0; i < D; i++) if (m_valid[i]) n--;
      return n;
   endfunction

   function automatic int m_lowest_free();
      for (int i = 0; i < D; i++) if (!m_valid[i]) return i;
      return 0;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < D; i++) begin
         m_valid[i] = 1'b0;
         m_ready[i] = 1'b0;
      end
      m_rr = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_free_cnt"}, free_cnt, D);
      check_val({tag, "_empty"}, empty, 1);
      check_val({tag, "_full"}, full, 0);
      check_val({tag, "_iss0_valid"}, iss0_valid, 0);
      check_val({tag, "_iss1_valid"}, iss1_valid, 0);
      check_val({tag, "_iss0_addr"}, iss0_addr, 0);
      check_val({tag, "_iss1_addr"}, iss1_addr, 0);
      check_val({tag, "_alloc_addr"}, alloc_addr, 0);
      check_val({tag, "_alloc_gnt"}, alloc_gnt, 0);
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance the
   // model at the edge and check registered outputs just after it.
   task automatic step(input bit req, input bit rdy, input bit wen, input int wa,
                       input bit sch, input bit fl);
      bit   gnt, t0, t1;
      int   aa, s0, s1;
      int   cand[$];
      logic [AW-1:0] wa_v;
      wa_v = wa[AW-1:0];
      @(negedge clk);
      alloc_req    = req;
      alloc_rdy_in = rdy;
      wake_en      = wen;
      wake_addr    = wa_v;
      schedule_en  = sch;
      flush        = fl;
      #1;
      gnt = req && (m_free() > 0) && !fl;
      aa  = m_lowest_free();
      check_val("alloc_gnt", alloc_gnt, gnt);
      check_val("alloc_addr", alloc_addr, aa);
      t0 = 1'b0; t1 = 1'b0; s0 = 0; s1 = 0;
      if (sch && !fl) begin
         for (int k = 0; k < D; k++) begin
            if (m_valid[(m_rr + k) % D] && m_ready[(m_rr + k) % D]) cand.push_back((m_rr + k) % D);
         end
         if (cand.size() > 0) begin t0 = 1'b1; s0 = cand[0]; end
         if (DUAL && cand.size() > 1) begin t1 = 1'b1; s1 = cand[1]; end
      end
      @(posedge clk);
      if (fl) begin
         m_clear();
      end else begin
         if (wen && (m_valid[wa] || (gnt && aa == wa))) m_ready[wa] = 1'b1;
         if (t0) begin m_valid[s0] = 1'b0; m_ready[s0] = 1'b0; m_rr = (s0 + 1) % D; end
         if (t1) begin m_valid[s1] = 1'b0; m_ready[s1] = 1'b0; m_rr = (s1 + 1) % D; end
         if (gnt) begin
            m_valid[aa] = 1'b1;
            m_ready[aa] = rdy || (wen && wa == aa);
         end
      end
      #1;
      check_val("iss0_valid", iss0_valid, t0);
      if (t0) check_val("iss0_addr", iss0_addr, s0);
      check_val("iss1_valid", iss1_valid, t1);
      if (t1) check_val("iss1_addr", iss1_addr, s1);
      check_val("free_cnt", free_cnt, m_free());
      check_val("full", full, m_free() == 0);
      check_val("empty", empty, m_free() == D);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_flush();
      step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; alloc_req = 1'b0; alloc_rdy_in = 1'b0;
      wake_en = 1'b0; wake_addr = '0; schedule_en = 1'b0;
      m_clear();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b1;

      // Back-to-back allocations of ready uops with scheduling on
      repeat (3) step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      check_val("dual_free_back", free_cnt, D);

      // Fill completely with non-ready entries
      for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      check_val("full_set", full, 1);
      step(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 7, 1'b1, 1'b0);
      check_val("full_no_early_issue", iss0_valid, 0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      check_val("full_iss0_valid", iss0_valid, 1);
      check_val("full_iss0_addr", iss0_addr, 7);
      check_val("full_cleared", full, 0);
      check_val("full_realloc_addr", alloc_addr, 7);
      step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Wakeup landing on the entry being allocated
      do_flush();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      check_val("wake_alloc_iss0_valid", iss0_valid, 1);
      check_val("wake_alloc_iss0_addr", iss0_addr, 5);
      step(1'b0, 1'b0, 1'b1, 9, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      check_val("wake_invalid_no_issue", iss0_valid, 0);

      // Round-robin ordering around a re-allocated low entry
      do_flush();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

      // Flush with six live entries and a concurrent request
      do_flush();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
      check_val("flush_free_cnt", free_cnt, D);
      check_val("flush_iss0_valid", iss0_valid, 0);
      idle();

      // Randomized traffic with one asynchronous reset in the middle
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(99) < 60, $urandom_range(99) < 35, $urandom_range(99) < 50,
              int'($urandom_range(D - 1)), $urandom_range(99) < 70, $urandom_range(199) == 0);
         if (c == 1500) begin
            #2;
            rst = 1'b0;
            #1;
            m_clear();
            alloc_req = 1'b0; wake_en = 1'b0; schedule_en = 1'b0; flush = 1'b0;
            #1;
            check_reset_state("midreset");
            @(negedge clk);
            rst = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
